// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and the
// slave's observable state bundle. Used by both the master and slave sides.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Snapshot of slave control state, intended for bind-in checkers.
    typedef struct packed {
        wr_state_t wr_state;
        rd_state_t rd_state;
        logic      aw_full;
        logic      w_full;
        logic      ready_en;
    } slave_dbg_t;

endpackage

// File: rtl/axi_lite_slave_regfile.sv
// Register bank for axi_lite_slave: one byte-enabled write port, one
// combinational read port and a flattened view of every register.
module axi_lite_slave_regfile #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     we,
    input  logic [IDX_W-1:0]         waddr,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic [IDX_W-1:0]         raddr,
    output logic [31:0]              rdata,
    output logic [NUM_REGS*32-1:0]   regs_out
);

    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read sees the pre-write value when a write lands on the same edge.
    assign rdata = mem[raddr];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[32*k +: 32] = mem[k];
    end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite responder over a bank of 32-bit registers. Write address/data are
// captured independently and committed together; reads are single-beat.
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h11111100
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [31:0]              ARADDR,
    input  logic [2:0]               ARPROT,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   regs_out
);

    localparam int          IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);

    // Wrapping subtraction turns addresses below the base into huge offsets,
    // so one unsigned compare covers both window edges.
    function automatic logic in_window(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off < WIN_BYTES;
    endfunction

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic        ready_en;
    logic        aw_full, w_full;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, ar_hs;
    logic        commit;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [3:0]  cur_strb;
    logic        wr_in_win, rd_in_win;
    logic [31:0] rf_rdata;

    slave_dbg_t  dbg;

    // Handshake semantics: a transfer happens on a rising edge where VALID and
    // READY are both high; VALIDs here come straight from registered state and
    // READYs depend only on internal state, never on an input.
    assign AWREADY = ready_en && !aw_full && (wr_state == WR_IDLE);
    assign WREADY  = ready_en && !w_full  && (wr_state == WR_IDLE);
    assign ARREADY = ready_en && (rd_state == RD_IDLE);
    assign BVALID  = (wr_state == WR_RESP);
    assign RVALID  = (rd_state == RD_DATA);
    assign BRESP   = bresp_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    assign cur_addr  = aw_full ? aw_addr_q : AWADDR;
    assign cur_data  = w_full  ? w_data_q  : WDATA;
    assign cur_strb  = w_full  ? w_strb_q  : WSTRB;
    assign commit    = (wr_state == WR_IDLE) && (aw_full || aw_hs) && (w_full || w_hs);
    assign wr_in_win = in_window(cur_addr);
    assign rd_in_win = in_window(ARADDR);

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (commit) wr_next = WR_RESP;
            WR_RESP: if (BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)  rd_next = RD_DATA;
            RD_DATA: if (RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            ready_en <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bresp_q <= wr_in_win ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_in_win ? rf_rdata : 32'h0;
            rresp_q <= rd_in_win ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axi_lite_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .we       (commit && wr_in_win),
        .waddr    (cur_addr[2 +: IDX_W]),
        .wdata    (cur_data),
        .wstrb    (cur_strb),
        .raddr    (ARADDR[2 +: IDX_W]),
        .rdata    (rf_rdata),
        .regs_out (regs_out)
    );

    assign dbg = '{wr_state: wr_state, rd_state: rd_state, aw_full: aw_full,
                   w_full: w_full, ready_en: ready_en};

    // PROT carries no meaning here; dbg exists for external observation only.
    logic unused_sink;
    assign unused_sink = ^{AWPROT, ARPROT, dbg};

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed bench for axi_lite_slave: each task drives one scenario and checks
// outputs 1ns after the rising edge against hand-computed values.
module tb_axi_lite_slave;

    localparam int NUM_REGS = 8;

    logic                   ACLK = 1'b0;
    logic                   ARESETn;
    logic                   AWVALID, AWREADY;
    logic [31:0]            AWADDR;
    logic [2:0]             AWPROT;
    logic                   WVALID, WREADY;
    logic [31:0]            WDATA;
    logic [3:0]             WSTRB;
    logic                   BVALID, BREADY;
    logic [1:0]             BRESP;
    logic                   ARVALID, ARREADY;
    logic [31:0]            ARADDR;
    logic [2:0]             ARPROT;
    logic                   RVALID, RREADY;
    logic [31:0]            RDATA;
    logic [1:0]             RRESP;
    logic [NUM_REGS*32-1:0] regs_out;

    logic [NUM_REGS*32-1:0] exp_regs;
    int n_vec = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_slave #(.NUM_REGS(NUM_REGS), .BASE_ADDR(32'h11111100)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .regs_out(regs_out)
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        AWVALID = 0; AWADDR = '0; AWPROT = 3'b010; WVALID = 0; WDATA = '0; WSTRB = '0;
        BREADY = 0; ARVALID = 0; ARADDR = '0; ARPROT = 3'b001; RREADY = 0;
        exp_regs = '0;
        step(); step();
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin n_err++; $display("FAIL reset_readys: got %b want 000", {AWREADY, WREADY, ARREADY}); end
        n_vec++; if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin n_err++; $display("FAIL reset_resp: got %b want 000000", {BVALID, RVALID, BRESP, RRESP}); end
        n_vec++; if (RDATA !== 32'h0 || regs_out !== exp_regs) begin n_err++; $display("FAIL reset_data: rdata %h regs %h want 0", RDATA, regs_out); end
        ARESETn = 1'b1;
        #1;
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin n_err++; $display("FAIL release_readys_early: got %b want 000", {AWREADY, WREADY, ARREADY}); end
        step();
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_err++; $display("FAIL release_readys: got %b want 111", {AWREADY, WREADY, ARREADY}); end
    endtask

    task automatic test_write_same_cycle();
        AWVALID = 1; AWADDR = 32'h11111110; WVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; BREADY = 1;
        step();
        AWVALID = 0; WVALID = 0;
        exp_regs[32*4 +: 32] = 32'hDEADBEEF;
        n_vec++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_err++; $display("FAIL same_cycle_b: bvalid %b bresp %b want 1 00", BVALID, BRESP); end
        n_vec++; if (regs_out !== exp_regs) begin n_err++; $display("FAIL same_cycle_regs: got %h want %h", regs_out, exp_regs); end
        n_vec++; if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin n_err++; $display("FAIL same_cycle_ready_low: aw %b w %b want 0 0", AWREADY, WREADY); end
        step();
        n_vec++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin n_err++; $display("FAIL same_cycle_done: bvalid %b awready %b want 0 1", BVALID, AWREADY); end
    endtask

    task automatic test_write_split();
        int bcount;
        WVALID = 1; WDATA = 32'hAABBCCDD; WSTRB = 4'b0101;
        step();
        WVALID = 0;
        n_vec++; if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0) begin n_err++; $display("FAIL split_w_held: wready %b awready %b bvalid %b want 0 1 0", WREADY, AWREADY, BVALID); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (WREADY !== 1'b0 || BVALID !== 1'b0) begin n_err++; $display("FAIL split_wait%0d: wready %b bvalid %b want 0 0", i, WREADY, BVALID); end
        end
        AWVALID = 1; AWADDR = 32'h11111104;
        step();
        AWVALID = 0;
        exp_regs[32*1 +: 32] = 32'h00BB00DD;
        n_vec++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_err++; $display("FAIL split_b: bvalid %b bresp %b want 1 00", BVALID, BRESP); end
        n_vec++; if (regs_out !== exp_regs) begin n_err++; $display("FAIL split_regs: got %h want %h", regs_out, exp_regs); end
        bcount = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (BVALID === 1'b1) bcount++;
        end
        n_vec++; if (bcount != 0) begin n_err++; $display("FAIL split_single_b: extra bvalid cycles %0d want 0", bcount); end
    endtask

    task automatic test_read_stall();
        RREADY = 0; ARVALID = 1; ARADDR = 32'h11111111;
        step();
        ARVALID = 0;
        n_vec++; if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || RRESP !== 2'b00) begin n_err++; $display("FAIL read_first: rvalid %b rdata %h rresp %b want 1 deadbeef 00", RVALID, RDATA, RRESP); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || ARREADY !== 1'b0) begin n_err++; $display("FAIL read_stall%0d: rvalid %b rdata %h arready %b want 1 deadbeef 0", i, RVALID, RDATA, ARREADY); end
        end
        RREADY = 1;
        step();
        RREADY = 0;
        n_vec++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin n_err++; $display("FAIL read_release: rvalid %b arready %b want 0 1", RVALID, ARREADY); end
    endtask

    task automatic test_out_of_window();
        AWVALID = 1; AWADDR = 32'h11111120; WVALID = 1; WDATA = 32'h12345678; WSTRB = 4'hF; BREADY = 1;
        step();
        AWVALID = 0; WVALID = 0;
        n_vec++; if (BVALID !== 1'b1 || BRESP !== 2'b10) begin n_err++; $display("FAIL oow_write_b: bvalid %b bresp %b want 1 10", BVALID, BRESP); end
        n_vec++; if (regs_out !== exp_regs) begin n_err++; $display("FAIL oow_write_regs: got %h want %h", regs_out, exp_regs); end
        step();
        RREADY = 1; ARVALID = 1; ARADDR = 32'h00000000;
        step();
        ARVALID = 0;
        n_vec++; if (RVALID !== 1'b1 || RDATA !== 32'h0 || RRESP !== 2'b10) begin n_err++; $display("FAIL oow_read: rvalid %b rdata %h rresp %b want 1 0 10", RVALID, RDATA, RRESP); end
        step();
        ARVALID = 1; ARADDR = 32'h111110FC;
        step();
        ARVALID = 0;
        n_vec++; if (RRESP !== 2'b10 || RDATA !== 32'h0) begin n_err++; $display("FAIL below_base_read: rdata %h rresp %b want 0 10", RDATA, RRESP); end
        step();
        ARVALID = 1; ARADDR = 32'h1111111C;
        step();
        ARVALID = 0;
        n_vec++; if (RRESP !== 2'b00 || RDATA !== 32'h0) begin n_err++; $display("FAIL top_reg_read: rdata %h rresp %b want 0 00", RDATA, RRESP); end
        step();
    endtask

    task automatic test_same_edge();
        AWVALID = 1; AWADDR = 32'h11111108; WVALID = 1; WDATA = 32'h12345678; WSTRB = 4'hF; BREADY = 1;
        ARVALID = 1; ARADDR = 32'h11111108; RREADY = 1;
        step();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        exp_regs[32*2 +: 32] = 32'h12345678;
        n_vec++; if (BVALID !== 1'b1 || RVALID !== 1'b1 || RDATA !== 32'h0) begin n_err++; $display("FAIL same_edge_old: bvalid %b rvalid %b rdata %h want 1 1 0", BVALID, RVALID, RDATA); end
        n_vec++; if (regs_out !== exp_regs) begin n_err++; $display("FAIL same_edge_regs: got %h want %h", regs_out, exp_regs); end
        step();
        ARVALID = 1;
        step();
        ARVALID = 0;
        n_vec++; if (RVALID !== 1'b1 || RDATA !== 32'h12345678) begin n_err++; $display("FAIL same_edge_new: rvalid %b rdata %h want 1 12345678", RVALID, RDATA); end
        step();
    endtask

    task automatic test_back_to_back();
        AWVALID = 1; AWADDR = 32'h11111114; WVALID = 1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; BREADY = 1;
        step();
        exp_regs[32*5 +: 32] = 32'hA5A5A5A5;
        n_vec++; if (BVALID !== 1'b1 || AWREADY !== 1'b0 || WREADY !== 1'b0 || regs_out !== exp_regs) begin n_err++; $display("FAIL b2b_first: bvalid %b aw %b w %b regs %h want 1 0 0 %h", BVALID, AWREADY, WREADY, regs_out, exp_regs); end
        AWADDR = 32'h11111118; WDATA = 32'h5A5A5A5A; WSTRB = 4'b1100;
        step();
        n_vec++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || regs_out !== exp_regs) begin n_err++; $display("FAIL b2b_gap: bvalid %b awready %b regs %h want 0 1 %h", BVALID, AWREADY, regs_out, exp_regs); end
        step();
        AWVALID = 0; WVALID = 0;
        exp_regs[32*6 +: 32] = 32'h5A5A0000;
        n_vec++; if (BVALID !== 1'b1 || regs_out !== exp_regs) begin n_err++; $display("FAIL b2b_second: bvalid %b regs %h want 1 %h", BVALID, regs_out, exp_regs); end
        step();
    endtask

    task automatic test_reset_mid();
        int stale;
        AWVALID = 1; AWADDR = 32'h1111111C; WVALID = 1; WDATA = 32'h01020304; WSTRB = 4'hF; BREADY = 0;
        ARVALID = 1; ARADDR = 32'h11111110; RREADY = 0;
        step();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        step();
        n_vec++; if (BVALID !== 1'b1 || RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL mid_pending: bvalid %b rvalid %b rdata %h want 1 1 deadbeef", BVALID, RVALID, RDATA); end
        #1 ARESETn = 1'b0;
        #1;
        exp_regs = '0;
        n_vec++; if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b0) begin n_err++; $display("FAIL mid_reset_ctl: got %b want 00000", {BVALID, RVALID, AWREADY, WREADY, ARREADY}); end
        n_vec++; if (RDATA !== 32'h0 || BRESP !== 2'b00 || RRESP !== 2'b00 || regs_out !== exp_regs) begin n_err++; $display("FAIL mid_reset_data: rdata %h bresp %b rresp %b regs %h want all 0", RDATA, BRESP, RRESP, regs_out); end
        step(); step();
        ARESETn = 1'b1; BREADY = 1; RREADY = 1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (BVALID === 1'b1 || RVALID === 1'b1) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL mid_stale_resp: %0d cycles with a response want 0", stale); end
        n_vec++; if (ARREADY !== 1'b1 || AWREADY !== 1'b1 || regs_out !== exp_regs) begin n_err++; $display("FAIL mid_recovered: arready %b awready %b regs %h want 1 1 0", ARREADY, AWREADY, regs_out); end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_split();
        test_read_stall();
        test_out_of_window();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave.md
# axi_lite_slave

AXI4-Lite responder (slave) holding a bank of software-visible 32-bit registers. It is the counterpart to the team's AXI4-Lite master and its per-channel master sub-blocks, and sits at the far end of the same five channels. It accepts write-address and write-data independently, commits byte-enabled writes and returns BRESP. Reads are answered from the register bank with RRESP.

## Interface
Parameters:
- NUM_REGS, 8, number of 32-bit registers; power of two, ≥2
- BASE_ADDR, 32'h11111100, byte address of register 0; aligned to NUM_REGS*4

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset; one clock, asynchronous assert, active-low
- AWVALID / AWREADY  in / out  1 / 1  write-address handshake
- AWADDR  in  32  write byte address
- AWPROT  in  3  accepted, ignored
- WVALID / WREADY  in / out  1 / 1  write-data handshake
- WDATA  in  32  write data
- WSTRB  in  4  byte enables; lane i covers bits 8i+7:8i
- BVALID / BREADY  out / in  1 / 1  write-response handshake
- BRESP  out  2  OKAY=2'b00, SLVERR=2'b10
- ARVALID / ARREADY  in / out  1 / 1  read-address handshake
- ARADDR  in  32  read byte address
- ARPROT  in  3  accepted, ignored
- RVALID / RREADY  out / in  1 / 1  read-data handshake
- RDATA  out  32  read data
- RRESP  out  2  OKAY / SLVERR
- regs_out  out  NUM_REGS*32  flattened register contents; reg k at bits 32k+31:32k

## Operation
- **Address decode:**
  - In window when BASE_ADDR ≤ addr < BASE_ADDR+4*NUM_REGS; index = addr[2+:log2(NUM_REGS)]; addr[1:0] ignored.
  - Out-of-window write: discarded, BRESP=SLVERR.
  - Out-of-window read: RDATA=0, RRESP=SLVERR.
- **Write path:** one AW holding register and one W holding register, each with a full flag.
  - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
  - AW and W may arrive in either order, or in the same cycle.
- **Write FSM:**
  - WR_IDLE → WR_RESP at the edge where the second of AW/W completes. Address/data are taken from the holding register or directly from the bus, whichever completes at that edge.
  - At that edge: lanes with WSTRB=1 are written, BVALID set, BRESP loaded, both full flags cleared.
  - WR_RESP → WR_IDLE on BVALID && BREADY.
  - WSTRB=4'b0000 in window: no bits change, BRESP=OKAY.
- **Read FSM:**
  - RD_IDLE: ARREADY=1. On handshake, RDATA/RRESP are loaded and RVALID set → RD_DATA.
  - RD_DATA: ARREADY=0, RDATA/RRESP held stable; → RD_IDLE on RVALID && RREADY.
- **Independence:** read and write paths are fully independent.
  - If a write commit and a read capture of the same register share an edge, the read returns the pre-write value.
- **Reset values:**
  - AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0; all registers 0; full flags 0; both FSMs idle.
  - READY outputs rise at the first edge after ARESETn deasserts.
- **Reset mid-transaction:** all held AW/W, pending B and pending R are dropped, with no response issued afterwards.

## Timing
- Write: if AW and W handshake at edge E, regs_out shows the new value and BVALID=1 in the cycle after E. A lone AW (or W) at E1 followed by the other at E2 gives BVALID after E2.
- Back-to-back writes: READYs are low while BVALID=1. Minimum 2 cycles per write when BREADY is held high.
- Read: ARVALID&&ARREADY at edge E gives RVALID=1 after E. Minimum 2 cycles per read when RREADY is held high.
- VALID outputs never drop without a handshake. BRESP, RDATA and RRESP are stable while their VALID is high.
- No combinational path from any input to any VALID output. READYs depend only on internal state.

## Structure
- **Shared package axi_lite_pkg:**
  - RESP_OKAY, RESP_SLVERR constants.
  - wr_state_t {WR_IDLE, WR_RESP}, rd_state_t {RD_IDLE, RD_DATA}.
  - The master side reuses the RESP constants.
- **Sub-module axi_lite_slave_regfile:** NUM_REGS×32 array with one byte-enabled write port, one combinational read port and the flattened regs_out. The top level holds both FSMs, the holding registers and the decode.

## Test plan
- AW=32'h11111110 and W=32'hDEADBEEF with WSTRB=4'hF in the same cycle, BREADY=1 → next cycle BVALID=1, BRESP=00; reg4=32'hDEADBEEF.
- AW=32'h11111104 three cycles after W=32'hAABBCCDD with WSTRB=4'b0101 (reg1 was 0) → reg1=32'h00BB00DD. WREADY stays 0 between the two handshakes; exactly one BVALID.
- Read of 32'h11111111 after the first test → RDATA=32'hDEADBEEF, RRESP=00. With RREADY held 0 for 4 cycles, RVALID/RDATA stay stable and ARREADY=0.
- Write to 32'h11111120 and read of 32'h00000000 → BRESP=10 with no register changed; RDATA=0, RRESP=10.
- Write commit to reg2 (32'h12345678) and read of reg2 at the same edge → RDATA returns the old value 0; a following read returns 32'h12345678.
- ARESETn pulsed low while BVALID=1 and RVALID=1 → all outputs at reset values, regs_out=0, and no stale response after release.
